period_meter: RTL

Measures the period and high time of a slow, asynchronous input, such as a divided-down clock, in cycles of the fast system clock. It is the receive-side counterpart of the team's clock divider: the divider turns `bigClk` into `smallClk`, and this block recovers the cycle counts from such a signal. It is used for self-check and for frequency monitoring in the FPGA top level.

---
 rtl/period_meter_pkg.sv | 10 +
 rtl/period_meter_if.sv | 14 +
 rtl/period_meter_edge_sync.sv | 32 +++
 rtl/period_meter.sv | 93 +++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter: FSM state encoding and
// default parameter values used by the interface and the top.
package period_meter_pkg;

  typedef enum logic {IDLE, MEASURE} meas_state_t;

  localparam int DEFAULT_CNT_W       = 24;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_if.sv
// Measurement interface: the slow input under test plus the captured
// period/high-time results and status flags.
interface period_meter_if import period_meter_pkg::*; #(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             sigIn;
  logic [CNT_W-1:0] periodOut;
  logic [CNT_W-1:0] highOut;
  logic             periodValid;
  logic             locked;

  modport master (output sigIn, input periodOut, highOut, periodValid, locked);
  modport slave  (input sigIn, output periodOut, highOut, periodValid, locked);
endinterface

// File: rtl/period_meter_edge_sync.sv
// Synchronizer chain plus history flop for an asynchronous input; emits
// single-cycle rise/fall strobes on the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2  // at least 2 for metastability settling
) (
  input  logic bigClk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge bigClk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;
endmodule

// File: rtl/period_meter.sv
// Measures rise-to-rise period and high time of a slow asynchronous input in
// bigClk cycles; drops lock when the counter saturates without a new rise.
module period_meter import period_meter_pkg::*; #(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input logic          bigClk,
  input logic          reset,
  period_meter_if.slave io
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rise, fall;
  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .bigClk (bigClk),
    .reset  (reset),
    .sig_in (io.sigIn),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // First rise only arms; a full period is needed before capturing.
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (fall) high_tmp_d = cnt_q;
        // A rise on the saturating cycle still captures.
        if (rise) begin
          period_d = cnt_q;
          high_d   = high_tmp_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bigClk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
    end
  end

  assign io.periodOut   = period_q;
  assign io.highOut     = high_q;
  assign io.periodValid = valid_q;
  assign io.locked      = locked_q;
endmodule
